// File: rtl/mux_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// mux_scan_ctrl_if
// Bundles every non-clock, non-reset signal of mux_scan_ctrl.
//   start     requester -> ctrl   start one scan (sampled only in IDLE)
//   data_in   requester -> ctrl   4-bit word to scan
//   a_out     ctrl -> mux         registered mux data inputs
//   sel       ctrl -> mux         registered mux select
//   mux_out   mux -> ctrl         single-bit mux result
//   busy      ctrl -> requester   scan in progress
//   done      ctrl -> requester   one-cycle completion pulse
//   word      ctrl -> requester   reassembled word
//   mismatch  ctrl -> requester   word != a_out, valid with done
// The slave modport is the controller; the master modport is its environment
// (requester plus the external mux).
// ---------------------------------------------------------------------------
interface mux_scan_ctrl_if;
  logic       start;
  logic [3:0] data_in;
  logic [3:0] a_out;
  logic [1:0] sel;
  logic       mux_out;
  logic       busy;
  logic       done;
  logic [3:0] word;
  logic       mismatch;

  modport master (
    output start, data_in, mux_out,
    input  a_out, sel, busy, done, word, mismatch
  );

  modport slave (
    input  start, data_in, mux_out,
    output a_out, sel, busy, done, word, mismatch
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// mux_scan_ctrl
// Drives a 4-bit word onto the data inputs of an external 4:1 mux, steps the
// select through 0..3, waits SETTLE cycles after each select change for the
// mux to settle, then samples the mux output into the matching bit of word.
// After the fourth sample a one-cycle done pulse reports the reassembled word
// and whether it differs from the driven word.
// Parameters:
//   SETTLE  settle cycles per select step, legal range 1..15
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset (aborts any scan, no done pulse)
//   bus     mux_scan_ctrl_if.slave, see the interface file for members
// ---------------------------------------------------------------------------
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic           clk,
  input  logic           rst,
  mux_scan_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  logic [1:0] state;
  logic [3:0] cnt;
  logic [3:0] a_out_q;
  logic [1:0] sel_q;
  logic [3:0] word_q;

  // The counter is loaded with SETTLE on every select change and the FSM
  // leaves SETTLE on the cycle the counter reads 1, so it spends exactly
  // SETTLE cycles there. Unsampled word bits keep the previous scan's value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      a_out_q <= 4'd0;
      sel_q   <= 2'd0;
      word_q  <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_out_q <= bus.data_in;
            sel_q   <= 2'd0;
            cnt     <= SETTLE_CNT;
            state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          word_q[sel_q] <= bus.mux_out;
          if (sel_q != 2'd3) begin
            sel_q <= sel_q + 2'd1;
            cnt   <= SETTLE_CNT;
            state <= ST_SETTLE;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.a_out    = a_out_q;
  assign bus.sel      = sel_q;
  assign bus.word     = word_q;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = (state == ST_DONE);
  // Gated by DONE so mismatch never shows a stale comparison between scans.
  assign bus.mismatch = (state == ST_DONE) && (word_q != a_out_q);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_ctrl
// Directed bench for mux_scan_ctrl. dut_a runs with SETTLE=2, dut_b with
// SETTLE=1. Each DUT drives a behavioural 4:1 mux with a 2 ns propagation
// delay (clock period 10 ns). dut_a's mux can be forced to output 0.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// Edge counts include the edge that accepts start as edge 1.
// ---------------------------------------------------------------------------
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_zero = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  mux_scan_ctrl_if ifa ();
  mux_scan_ctrl_if ifb ();

  mux_scan_ctrl #(.SETTLE(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  mux_scan_ctrl #(.SETTLE(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  always #5 clk = ~clk;

  // Behavioural muxes with gate delay well under one clock period.
  assign #2 ifa.mux_out = force_zero ? 1'b0 : ifa.a_out[ifa.sel];
  assign #2 ifb.mux_out = ifb.a_out[ifb.sel];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] d);
    ifa.start   = s;
    ifa.data_in = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a scan on dut_a and returns once done is seen (or budget expires).
  task automatic scanA(input logic [3:0] d, output int edges);
    applyStimulus(1'b1, d);
    tick();
    applyStimulus(1'b0, d);
    edges = 1;
    while (!ifa.done && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    int n;
    int pulses;
    logic [3:0] seq [4];
    seq[0] = 4'hA; seq[1] = 4'hC; seq[2] = 4'hB; seq[3] = 4'h0;

    ifa.start = 1'b0; ifa.data_in = 4'h0;
    ifb.start = 1'b0; ifb.data_in = 4'h0;

    // ---------------- reset state ----------------
    tick();
    tick();
    checkOutput("rst_busy",     ifa.busy,     0);
    checkOutput("rst_done",     ifa.done,     0);
    checkOutput("rst_mismatch", ifa.mismatch, 0);
    checkOutput("rst_sel",      ifa.sel,      0);
    checkOutput("rst_a_out",    ifa.a_out,    0);
    checkOutput("rst_word",     ifa.word,     0);
    checkOutput("rst_b_busy",   ifb.busy,     0);
    rst = 1'b0;
    tick();
    checkOutput("idle_busy", ifa.busy, 0);

    // ---------------- single scan of 4'hE, per-edge trace ----------------
    applyStimulus(1'b1, 4'hE);
    tick();
    applyStimulus(1'b0, 4'h0);
    checkOutput("e_accept_busy", ifa.busy,  1);
    checkOutput("e_accept_aout", ifa.a_out, 4'hE);
    checkOutput("e_accept_sel",  ifa.sel,   0);
    for (int j = 1; j <= 12; j++) begin
      tick();
      checkOutput($sformatf("e_sel_%0d", j), ifa.sel, (j / 3 > 3) ? 3 : j / 3);
      checkOutput($sformatf("e_done_%0d", j), ifa.done, (j == 12) ? 1 : 0);
      if (j != 12) checkOutput($sformatf("e_mm_%0d", j), ifa.mismatch, 0);
      checkOutput($sformatf("e_aout_%0d", j), ifa.a_out, 4'hE);
    end
    checkOutput("e_word",     ifa.word,     4'hE);
    checkOutput("e_mismatch", ifa.mismatch, 0);
    checkOutput("e_busy_done", ifa.busy,    1);
    tick();
    checkOutput("e_done_drop", ifa.done,    0);
    checkOutput("e_busy_drop", ifa.busy,    0);
    checkOutput("e_hold_word", ifa.word,    4'hE);
    checkOutput("e_hold_aout", ifa.a_out,   4'hE);
    checkOutput("e_hold_sel",  ifa.sel,     3);
    tick();
    checkOutput("e_idle_busy", ifa.busy,    0);

    // ---------------- back-to-back scans ----------------
    scanA(seq[0], n);
    checkOutput("b2b0_latency", n, 13);
    checkOutput("b2b0_word", ifa.word, seq[0]);
    checkOutput("b2b0_mm",   ifa.mismatch, 0);
    for (int k = 1; k < 4; k++) begin
      applyStimulus(1'b1, seq[k]);
      tick();
      checkOutput($sformatf("b2b%0d_gap_busy", k), ifa.busy, 0);
      checkOutput($sformatf("b2b%0d_gap_aout", k), ifa.a_out, seq[k-1]);
      tick();
      applyStimulus(1'b0, seq[k]);
      checkOutput($sformatf("b2b%0d_busy", k), ifa.busy, 1);
      checkOutput($sformatf("b2b%0d_aout", k), ifa.a_out, seq[k]);
      n = 1;
      while (!ifa.done && n < 40) begin
        tick();
        n++;
      end
      checkOutput($sformatf("b2b%0d_latency", k), n, 13);
      checkOutput($sformatf("b2b%0d_word", k), ifa.word, seq[k]);
      checkOutput($sformatf("b2b%0d_mm", k), ifa.mismatch, 0);
    end
    tick();
    tick();

    // ---------------- stuck-at-0 mux, 4'hA ----------------
    force_zero = 1'b1;
    scanA(4'hA, n);
    checkOutput("sa0_latency", n, 13);
    checkOutput("sa0_word",    ifa.word,     4'h0);
    checkOutput("sa0_mm",      ifa.mismatch, 1);
    tick();
    checkOutput("sa0_mm_drop", ifa.mismatch, 0);
    checkOutput("sa0_done_drop", ifa.done,   0);
    force_zero = 1'b0;
    tick();

    // ---------------- start ignored mid-scan ----------------
    applyStimulus(1'b1, 4'h6);
    tick();
    applyStimulus(1'b0, 4'h6);
    n = 0;
    while (ifa.sel != 2'd2 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("ign_reach_sel2", ifa.sel, 2);
    applyStimulus(1'b1, 4'h5);
    tick();
    applyStimulus(1'b0, 4'h5);
    checkOutput("ign_aout", ifa.a_out, 4'h6);
    checkOutput("ign_sel",  ifa.sel,   2);
    pulses = 0;
    for (int j = 0; j < 20; j++) begin
      if (ifa.done) begin
        pulses++;
        checkOutput("ign_word", ifa.word, 4'h6);
      end
      tick();
    end
    checkOutput("ign_pulses", pulses, 1);
    checkOutput("ign_aout_end", ifa.a_out, 4'h6);
    checkOutput("ign_idle", ifa.busy, 0);

    // ---------------- reset mid-scan ----------------
    applyStimulus(1'b1, 4'h9);
    tick();
    applyStimulus(1'b0, 4'h9);
    n = 0;
    while (ifa.sel != 2'd2 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("rsm_reach_sel2", ifa.sel, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rsm_sel",  ifa.sel,  0);
    checkOutput("rsm_word", ifa.word, 0);
    checkOutput("rsm_aout", ifa.a_out, 0);
    checkOutput("rsm_busy", ifa.busy, 0);
    checkOutput("rsm_done", ifa.done, 0);
    scanA(4'h7, n);
    checkOutput("rsm_new_latency", n, 13);
    checkOutput("rsm_new_word", ifa.word, 4'h7);
    checkOutput("rsm_new_mm",   ifa.mismatch, 0);
    tick();

    // ---------------- SETTLE=1 instance ----------------
    ifb.start   = 1'b1;
    ifb.data_in = 4'h3;
    tick();
    ifb.start   = 1'b0;
    checkOutput("s1_busy", ifb.busy, 1);
    n = 1;
    while (!ifb.done && n < 40) begin
      tick();
      n++;
    end
    checkOutput("s1_latency", n, 9);
    checkOutput("s1_word", ifb.word, 4'h3);
    checkOutput("s1_mm",   ifb.mismatch, 0);
    tick();
    checkOutput("s1_done_drop", ifb.done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SETTLE, default 2: clock cycles held after each select change before sampling the mux output; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to scan one 4-bit word; sampled only in IDLE.
REQ-005 data_in  input  4  word to scan; captured on an accepted start.
REQ-006 a_out  output  4  registered data bus driven to the 4:1 mux data inputs.
REQ-007 sel  output  2  registered select driven to the mux select inputs.
REQ-008 mux_out  input  1  single-bit mux result returned to this block.
REQ-009 busy  output  1  high from the cycle after start is accepted until DONE is left.
REQ-010 done  output  1  one-cycle pulse; word and mismatch are valid while it is high.
REQ-011 word  output  4  reassembled word; bit k is mux_out sampled while sel=k.
REQ-012 mismatch  output  1  high when word != a_out; valid only while done=1.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, SETTLE, SAMPLE, DONE.
REQ-014 IDLE with start=1: a_out<=data_in, sel<=0, settle counter<=SETTLE, next state SETTLE.
REQ-015 IDLE with start=0: all outputs hold; stay in IDLE.
REQ-016 SETTLE: counter decrements once per cycle and the FSM stays exactly SETTLE cycles, then enters SAMPLE; sel and a_out stay stable throughout.
REQ-017 SAMPLE (one cycle): word[sel]<=mux_out.
REQ-018 SAMPLE with sel<3: sel<=sel+1, counter<=SETTLE, next state SETTLE.
REQ-019 SAMPLE with sel=3: sel holds at 3, next state DONE.
REQ-020 DONE (one cycle): done=1 and mismatch=(word!=a_out); next state IDLE.
REQ-021 Latency: done is high exactly 4*(SETTLE+1)+1 rising edges after the edge that accepts start (13 for SETTLE=2).
REQ-022 busy = (state is SETTLE, SAMPLE or DONE).
REQ-023 start is ignored in SETTLE, SAMPLE and DONE; it has no effect on a_out, sel or the counter.
REQ-024 A start present in the first IDLE cycle after DONE is accepted, so back-to-back scans have a 1-cycle IDLE gap.
REQ-025 word, a_out and sel hold their last values in IDLE after DONE until the next accepted start.
REQ-026 word bits not yet sampled in the current scan retain their values from the previous scan.
REQ-027 mismatch SHALL be 0 whenever done=0.
REQ-028 An X/Z value on mux_out is sampled as-is; the FSM does not depend on mux_out.

Reset
REQ-029 While rst=1 at a rising edge: state<=IDLE, sel<=0, a_out<=0, word<=0, counter<=0, busy=0, done=0, mismatch=0.
REQ-030 rst has priority over start and over every state transition, including mid-scan; any scan in progress is aborted with no done pulse.
REQ-031 After rst deasserts, start is accepted on the first clock edge.

Verification
REQ-032 SETTLE=2, mux model with gate delays below one clock period, data_in=4'hE, start pulse -> sel steps 0,1,2,3 with 3 cycles per step; done 13 edges after start; word=4'hE; mismatch=0.
REQ-033 Sequential scans of 4'hA, 4'hC, 4'hB, 4'h0 -> each word equals its input; mismatch=0 every time; 1-cycle IDLE gap between scans.
REQ-034 mux_out forced to 0, data_in=4'hA -> word=4'h0, mismatch=1 for exactly one cycle.
REQ-035 start re-asserted with data_in=4'h5 during SETTLE after sel=2 -> ignored; a_out stays at the original word; a single done pulse.
REQ-036 rst asserted while sel=2 -> next edge: IDLE, sel=0, word=0, busy=0, no done pulse; a new start after rst completes normally.
REQ-037 SETTLE=1, data_in=4'h3 -> done 9 edges after start; word=4'h3.
